// File: rtl/clk_div_prog.sv
// Runtime-programmable integer clock divider with optional half-cycle high extension.
// Configuration is sampled only at output-period boundaries so div_clk never glitches.
module clk_div_prog #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [CNT_W-1:0] div_ratio,
  input  logic [CNT_W-1:0] high_cnt,
  input  logic             half_en,
  output logic             div_clk,
  output logic             period_st,
  output logic             cfg_err
);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] TWO = CNT_W'(2);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [CNT_W-1:0] n_s, n_s_nxt;
  logic [CNT_W-1:0] h_s, h_s_nxt;
  logic             half_s, half_s_nxt;
  logic             clk_p, clk_p_nxt;
  logic             clk_n;
  logic             period_st_nxt, cfg_err_nxt;

  logic [CNT_W-1:0] n_ld, h_ld, cnt_inc, n_last;
  logic             ratio_clamp, high_clamp;

  // Clamped view of the live inputs, used only at a config load.
  always_comb begin
    ratio_clamp = (div_ratio < TWO);
    n_ld        = ratio_clamp ? TWO : div_ratio;
    high_clamp  = (high_cnt == '0) || (high_cnt >= n_ld);
    if (high_cnt == '0) begin
      h_ld = ONE;
    end else if (high_cnt >= n_ld) begin
      h_ld = n_ld - ONE;
    end else begin
      h_ld = high_cnt;
    end
  end

  assign cnt_inc = cnt + ONE;
  assign n_last  = n_s - ONE;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_nxt     = state;
    cnt_nxt       = cnt;
    n_s_nxt       = n_s;
    h_s_nxt       = h_s;
    half_s_nxt    = half_s;
    clk_p_nxt     = clk_p;
    period_st_nxt = 1'b0;
    cfg_err_nxt   = 1'b0;

    unique case (state)
      IDLE: begin
        cnt_nxt   = '0;
        clk_p_nxt = 1'b0;
        if (en) begin
          state_nxt     = RUN;
          n_s_nxt       = n_ld;
          h_s_nxt       = h_ld;
          half_s_nxt    = half_en;
          clk_p_nxt     = 1'b1;
          period_st_nxt = 1'b1;
          cfg_err_nxt   = ratio_clamp || high_clamp;
        end
      end
      RUN: begin
        if (cnt != n_last) begin
          cnt_nxt   = cnt_inc;
          clk_p_nxt = (cnt_inc < h_s);
        end else if (en) begin
          cnt_nxt       = '0;
          n_s_nxt       = n_ld;
          h_s_nxt       = h_ld;
          half_s_nxt    = half_en;
          clk_p_nxt     = 1'b1;
          period_st_nxt = 1'b1;
          cfg_err_nxt   = ratio_clamp || high_clamp;
        end else begin
          // Stop only after the final period has run to completion.
          state_nxt = IDLE;
          cnt_nxt   = '0;
          clk_p_nxt = 1'b0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      n_s       <= TWO;
      h_s       <= ONE;
      half_s    <= 1'b0;
      clk_p     <= 1'b0;
      period_st <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      n_s       <= n_s_nxt;
      h_s       <= h_s_nxt;
      half_s    <= half_s_nxt;
      clk_p     <= clk_p_nxt;
      period_st <= period_st_nxt;
      cfg_err   <= cfg_err_nxt;
    end
  end

  // Falling-edge copy stretches the high phase by half a source period.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_n <= 1'b0;
    end else begin
      clk_n <= clk_p;
    end
  end

  assign div_clk = half_s ? (clk_p | clk_n) : clk_p;

endmodule

// File: tb/tb_clk_div_prog.sv
// Bench for clk_div_prog: table-driven config vectors, directed corner sequences
// and a random sweep, with per-period measurements compared against a scoreboard.
module tb_clk_div_prog;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [7:0] div_ratio;
  logic [7:0] high_cnt;
  logic       half_en;
  logic       div_clk;
  logic       period_st;
  logic       cfg_err;

  clk_div_prog #(.CNT_W(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .div_ratio(div_ratio),
    .high_cnt (high_cnt),
    .half_en  (half_en),
    .div_clk  (div_clk),
    .period_st(period_st),
    .cfg_err  (cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] r;
    logic [7:0] h;
    logic       hf;
    int         n;
    int         hh;
    int         er;
  } cfg_t;

  typedef struct {
    int halves;
    int high;
    int st;
    int er;
  } meas_t;

  int    errors = 0;
  int    checks = 0;
  cfg_t  plan[$];
  meas_t sb[$];
  cfg_t  vecs[10];

  bit mon_on = 1'b0;
  bit have_rise = 1'b0;
  bit prev = 1'b0;
  int mon_halves, mon_high, mon_st, mon_er;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic cfg_t mk(input logic [7:0] r, input logic [7:0] h, input logic hf,
                              input int n, input int hh, input int er);
    cfg_t c;
    c.r = r; c.h = h; c.hf = hf; c.n = n; c.hh = hh; c.er = er;
    return c;
  endfunction

  // Independent clamp model for the random sweep.
  function automatic cfg_t model(input logic [7:0] r, input logic [7:0] h, input logic hf);
    int n, hh, er;
    n  = (r < 2) ? 2 : int'(r);
    hh = (h == 0) ? 1 : (int'(h) >= n) ? n - 1 : int'(h);
    er = ((r < 2) || (h == 0) || (int'(h) >= n)) ? 1 : 0;
    return mk(r, h, hf, n, hh, er);
  endfunction

  // Half-cycle resolution sampler; a div_clk rise closes the previous period.
  task automatic sample(input bit pos);
    bit    cur;
    meas_t e;
    cur = div_clk;
    if (!mon_on) begin
      have_rise = 1'b0;
      prev = cur;
      return;
    end
    if (cur && !prev) begin
      if (have_rise) begin
        if (sb.size() == 0) begin
          check("sb_unexpected_period", 1, 0);
        end else begin
          e = sb.pop_front();
          check("period_halves", mon_halves, e.halves);
          check("high_halves", mon_high, e.high);
          check("period_st_count", mon_st, e.st);
          check("cfg_err_count", mon_er, e.er);
        end
      end
      have_rise  = 1'b1;
      mon_halves = 0;
      mon_high   = 0;
      mon_st     = 0;
      mon_er     = 0;
    end
    mon_halves++;
    mon_high += int'(cur);
    if (pos) begin
      mon_st += int'(period_st);
      mon_er += int'(cfg_err);
    end
    prev = cur;
  endtask

  initial begin : monitor
    forever begin
      @(posedge clk); #2; sample(1'b1);
      @(negedge clk); #2; sample(1'b0);
    end
  end

  task automatic drive(input cfg_t c);
    div_ratio = c.r;
    high_cnt  = c.h;
    half_en   = c.hf;
  endtask

  // Runs the configs in plan back to back, each written at cnt=1 of the preceding period.
  task automatic run_plan();
    cfg_t  cur;
    meas_t m;
    cur = plan[0];
    drive(cur);
    en = 1'b1;
    mon_on = 1'b1;
    @(posedge clk); #2;
    check("cfg_err_load", cfg_err, cur.er);
    for (int k = 1; k < plan.size(); k++) begin
      @(posedge clk); #2;
      drive(plan[k]);
      repeat (cur.n - 1) @(posedge clk);
      #1;
      m.halves = 2 * cur.n; m.high = 2 * cur.hh + int'(cur.hf); m.st = 1; m.er = cur.er;
      sb.push_back(m);
      cur = plan[k];
      #1;
      check("cfg_err_load", cfg_err, cur.er);
    end
    @(posedge clk); #1;
    en = 1'b0;
    repeat (cur.n - 1) @(posedge clk);
    #3;
    check("idle_after_run", div_clk, 0);
    check("last_period_high", mon_high, 2 * cur.hh + int'(cur.hf));
    check("sb_drained", sb.size(), 0);
    mon_on = 1'b0;
    repeat (2) @(posedge clk);
    #2;
  endtask

  initial begin : stim
    logic [7:0] rr, hr;

    vecs[0] = mk(8'd5,   8'd2,   1'b1, 5,   2,   0);
    vecs[1] = mk(8'd4,   8'd2,   1'b0, 4,   2,   0);
    vecs[2] = mk(8'd1,   8'd0,   1'b0, 2,   1,   1);
    vecs[3] = mk(8'd3,   8'd5,   1'b0, 3,   2,   1);
    vecs[4] = mk(8'd2,   8'd1,   1'b1, 2,   1,   0);
    vecs[5] = mk(8'd0,   8'd3,   1'b0, 2,   1,   1);
    vecs[6] = mk(8'd255, 8'd254, 1'b1, 255, 254, 0);
    vecs[7] = mk(8'd255, 8'd255, 1'b0, 255, 254, 1);
    vecs[8] = mk(8'd7,   8'd3,   1'b1, 7,   3,   0);
    vecs[9] = mk(8'd6,   8'd6,   1'b0, 6,   5,   1);

    rst_n = 1'b0; en = 1'b0; div_ratio = 8'd0; high_cnt = 8'd0; half_en = 1'b0;
    #3;
    check("reset_div_clk", div_clk, 0);
    check("reset_period_st", period_st, 0);
    check("reset_cfg_err", cfg_err, 0);
    #9 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    check("idle_no_en_div_clk", div_clk, 0);
    check("idle_no_en_period_st", period_st, 0);

    // Each table vector runs three periods of the same config.
    foreach (vecs[i]) begin
      plan.delete();
      repeat (3) plan.push_back(vecs[i]);
      run_plan();
    end

    // Reconfigure mid-period: the running 4-clk period is unaffected.
    plan.delete();
    plan.push_back(mk(8'd4, 8'd2, 1'b0, 4, 2, 0));
    plan.push_back(mk(8'd6, 8'd1, 1'b0, 6, 1, 0));
    plan.push_back(mk(8'd6, 8'd1, 1'b0, 6, 1, 0));
    run_plan();

    // en dropped at cnt=1 of a 7-clk period, then re-asserted.
    @(posedge clk); #1;
    div_ratio = 8'd7; high_cnt = 8'd3; half_en = 1'b0; en = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 11; i++) begin
      #2;
      check($sformatf("en_drop_div_clk_%0d", i), div_clk, (i < 3) ? 1 : 0);
      if (i == 1) en = 1'b0;
      @(posedge clk);
    end
    #1 en = 1'b1;
    #1 check("restart_before_sample", div_clk, 0);
    @(posedge clk); #2;
    check("restart_div_clk", div_clk, 1);
    check("restart_period_st", period_st, 1);
    en = 1'b0;
    repeat (8) @(posedge clk);
    #2;
    check("restart_stops", div_clk, 0);

    // Asynchronous reset during the high phase of a 9-clk period.
    @(posedge clk); #1;
    div_ratio = 8'd9; high_cnt = 8'd4; half_en = 1'b0; en = 1'b1;
    @(posedge clk);
    repeat (2) @(posedge clk);
    #2 check("rst_pre_high", div_clk, 1);
    #1 rst_n = 1'b0;
    #1;
    check("rst_async_div_clk", div_clk, 0);
    check("rst_async_period_st", period_st, 0);
    check("rst_async_cfg_err", cfg_err, 0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #2;
    check("rst_resume_div_clk", div_clk, 1);
    check("rst_resume_period_st", period_st, 1);
    check("rst_resume_cfg_err", cfg_err, 0);
    en = 1'b0;
    repeat (10) @(posedge clk);
    #2;

    // Random config sweep, a new config at every wrap.
    plan.delete();
    for (int i = 0; i < 40; i++) begin
      rr = 8'($urandom_range(2, 255));
      hr = 8'($urandom_range(0, int'(rr)));
      plan.push_back(model(rr, hr, 1'($urandom_range(0, 1))));
    end
    run_plan();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
